// File: rtl/rgb_frame_source.sv
// rtl/rgb_frame_source.sv - raster RGB test-pattern source with programmable blanking
// Optional FRAME_CHECKSUM_EN adds a per-frame R+G+B checksum on frame_sum/sum_valid.
module rgb_frame_source #(
    parameter int IMG_WIDTH  = 400,
    parameter int IMG_HEIGHT = 300,
    parameter int HBLANK     = 16,
    parameter int VBLANK     = 64,
    parameter int CW         = 12
) (
    input  logic          pixclk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    num_frames,
    input  logic [1:0]    pattern_sel,
    output logic          oValid,
    output logic [7:0]    oRed,
    output logic [7:0]    oGreen,
    output logic [7:0]    oBlue,
    output logic          oSof,
    output logic          oEol,
    output logic          oEof,
    output logic [CW-1:0] oX,
    output logic [CW-1:0] oY,
    output logic          busy,
    output logic          done,
    output logic [7:0]    frame_cnt,
    output logic [31:0]   frame_sum,
    output logic          sum_valid
);

    localparam int BW  = IMG_WIDTH / 8;
    localparam int BCW = 16;

    localparam logic [CW-1:0]  X_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]  Y_LAST  = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0]  BW_LAST = CW'(BW - 1);
    localparam logic [BCW-1:0] HB_LAST = BCW'(HBLANK - 1);
    localparam logic [BCW-1:0] VB_LAST = BCW'(VBLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  cx;
    logic [CW-1:0]  cy;
    logic [CW-1:0]  nx;
    logic [CW-1:0]  ny;
    logic [CW-1:0]  bar_pos;
    logic [CW-1:0]  pos_n;
    logic [2:0]     bar_idx;
    logic [2:0]     bar_n;
    logic [BCW-1:0] bcnt;
    logic [BCW-1:0] bcnt_n;
    logic [1:0]     pat_lat;
    logic [1:0]     pat_n;
    logic [7:0]     num_lat;
    logic [7:0]     fc_pix;
    logic [7:0]     ramp_v;
    logic [23:0]    rgb_n;
    logic           stop_pend;
    logic           emit;
    logic           sof_n;
    logic           fc_inc;
    logic           done_n;
    logic           run_end;

    always_comb begin
        state_n = state;
        emit    = 1'b0;
        nx      = '0;
        ny      = '0;
        bcnt_n  = bcnt;
        fc_inc  = 1'b0;
        done_n  = 1'b0;
        run_end = ((num_lat != 8'd0) && (frame_cnt == num_lat)) || stop_pend || stop;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_ACTIVE;
                    emit    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cx == X_LAST) begin
                    if (cy == Y_LAST) fc_inc = 1'b1;
                    if (HBLANK > 0) begin
                        state_n = S_HBLANK;
                        bcnt_n  = '0;
                    end else if (cy == Y_LAST) begin
                        state_n = S_VBLANK;
                        bcnt_n  = '0;
                    end else begin
                        emit = 1'b1;
                        ny   = cy + 1'b1;
                    end
                end else begin
                    emit = 1'b1;
                    nx   = cx + 1'b1;
                    ny   = cy;
                end
            end
            S_HBLANK: begin
                if (bcnt == HB_LAST) begin
                    if (cy == Y_LAST) begin
                        state_n = S_VBLANK;
                        bcnt_n  = '0;
                    end else begin
                        state_n = S_ACTIVE;
                        emit    = 1'b1;
                        ny      = cy + 1'b1;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
            S_VBLANK: begin
                // The frame is always finished before a halt is honoured.
                if (bcnt == VB_LAST) begin
                    if (run_end) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_ACTIVE;
                        emit    = 1'b1;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        sof_n  = emit && (nx == '0) && (ny == '0);
        pat_n  = sof_n ? pattern_sel : pat_lat;
        fc_pix = (state == S_IDLE) ? 8'd0 : frame_cnt;
        ramp_v = fc_pix + nx[7:0];

        // Bar position tracked incrementally; bar 7 keeps counting to absorb the remainder.
        if (nx == '0) begin
            bar_n = 3'd0;
            pos_n = '0;
        end else if ((bar_pos == BW_LAST) && (bar_idx != 3'd7)) begin
            bar_n = bar_idx + 1'b1;
            pos_n = '0;
        end else begin
            bar_n = bar_idx;
            pos_n = bar_pos + 1'b1;
        end

        case (pat_n)
            2'd0:    rgb_n = {nx[7:0], ny[7:0], nx[7:0] ^ ny[7:0]};
            2'd1:    rgb_n = {{8{~bar_n[1]}}, {8{~bar_n[2]}}, {8{~bar_n[0]}}};
            2'd2:    rgb_n = (nx[4] ^ ny[4]) ? 24'h000000 : 24'hFFFFFF;
            default: rgb_n = {ramp_v, ramp_v, ramp_v};
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cx        <= '0;
            cy        <= '0;
            bar_idx   <= '0;
            bar_pos   <= '0;
            bcnt      <= '0;
            pat_lat   <= '0;
            num_lat   <= '0;
            stop_pend <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            oValid    <= 1'b0;
            oSof      <= 1'b0;
            oEol      <= 1'b0;
            oEof      <= 1'b0;
            oX        <= '0;
            oY        <= '0;
            oRed      <= '0;
            oGreen    <= '0;
            oBlue     <= '0;
        end else begin
            state <= state_n;
            bcnt  <= bcnt_n;
            done  <= done_n;
            busy  <= (state_n == S_ACTIVE) || (state_n == S_HBLANK) || (state_n == S_VBLANK);

            if (emit) begin
                cx      <= nx;
                cy      <= ny;
                bar_idx <= bar_n;
                bar_pos <= pos_n;
            end
            if (sof_n) pat_lat <= pattern_sel;

            if ((state == S_IDLE) && start) begin
                frame_cnt <= 8'd0;
                num_lat   <= num_frames;
            end else if (fc_inc) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if ((state == S_IDLE) || (state == S_DONE)) stop_pend <= 1'b0;
            else if (stop)                              stop_pend <= 1'b1;

            oValid <= emit;
            oSof   <= sof_n;
            oEol   <= emit && (nx == X_LAST);
            oEof   <= emit && (nx == X_LAST) && (ny == Y_LAST);
            oX     <= nx;
            oY     <= ny;
            {oRed, oGreen, oBlue} <= emit ? rgb_n : 24'h000000;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [31:0] acc;
    logic [31:0] pix_sum;

    assign pix_sum = 32'(oRed) + 32'(oGreen) + 32'(oBlue);

    always_ff @(posedge pixclk) begin
        if (!reset) begin
            acc       <= '0;
            frame_sum <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (oValid) begin
                acc <= (oSof ? 32'd0 : acc) + pix_sum;
                if (oEof) begin
                    frame_sum <= acc + pix_sum;
                    sum_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign frame_sum = 32'd0;
    assign sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_frame_source.sv
// tb/tb_rgb_frame_source.sv - randomized bench for rgb_frame_source against a raster model
module tb_rgb_frame_source;

    localparam int PW  [2] = '{8, 20};
    localparam int PH  [2] = '{4, 2};
    localparam int PHB [2] = '{2, 0};
    localparam int PVB [2] = '{3, 2};
    localparam int BIG = 1000000;
    localparam logic [23:0] BAR_COL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic pixclk;
    logic [1:0] rstn, start, stop;
    logic [1:0][7:0] num;
    logic [1:0][1:0] psel;
    wire  [1:0] valid, sof, eol, eof, busy, done, sv;
    wire  [1:0][7:0] red, grn, blu, fcnt;
    wire  [1:0][11:0] ox, oy;
    wire  [1:0][31:0] fsum;

    logic [31:0] fs_model [2];
    int n_checks = 0;
    int n_pass = 0;

    rgb_frame_source #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .HBLANK(2), .VBLANK(3), .CW(12)) u_dut_a (
        .pixclk(pixclk), .reset(rstn[0]), .start(start[0]), .stop(stop[0]),
        .num_frames(num[0]), .pattern_sel(psel[0]), .oValid(valid[0]),
        .oRed(red[0]), .oGreen(grn[0]), .oBlue(blu[0]), .oSof(sof[0]), .oEol(eol[0]),
        .oEof(eof[0]), .oX(ox[0]), .oY(oy[0]), .busy(busy[0]), .done(done[0]),
        .frame_cnt(fcnt[0]), .frame_sum(fsum[0]), .sum_valid(sv[0]));

    rgb_frame_source #(.IMG_WIDTH(20), .IMG_HEIGHT(2), .HBLANK(0), .VBLANK(2), .CW(12)) u_dut_b (
        .pixclk(pixclk), .reset(rstn[1]), .start(start[1]), .stop(stop[1]),
        .num_frames(num[1]), .pattern_sel(psel[1]), .oValid(valid[1]),
        .oRed(red[1]), .oGreen(grn[1]), .oBlue(blu[1]), .oSof(sof[1]), .oEol(eol[1]),
        .oEof(eof[1]), .oX(ox[1]), .oY(oy[1]), .busy(busy[1]), .done(done[1]),
        .frame_cnt(fcnt[1]), .frame_sum(fsum[1]), .sum_valid(sv[1]));

    always #5 pixclk = ~pixclk;

    function automatic logic [23:0] model_pix(int x, int y, logic [1:0] p, logic [7:0] fc, int w);
        logic [7:0] xb, yb, v;
        int bar;
        xb = 8'(x);
        yb = 8'(y);
        case (p)
            2'd0: return {xb, yb, xb ^ yb};
            2'd1: begin
                bar = x / (w / 8);
                if (bar > 7) bar = 7;
                return BAR_COL[bar];
            end
            2'd2: return (xb[4] ^ yb[4]) ? 24'h000000 : 24'hFFFFFF;
            default: begin
                v = fc + xb;
                return {v, v, v};
            end
        endcase
    endfunction

    function automatic logic [53:0] obs(int k);
        return {valid[k], sof[k], eol[k], eof[k], busy[k], done[k], ox[k], oy[k], red[k], grn[k], blu[k]};
    endfunction

    // Starts a run on instance k and compares every cycle to the raster model until the
    // IDLE cycle after done, or until cycle max_t.
    task automatic run_stream(input int k, input int nf, input int stop_t, input int max_t,
                              input bit rand_pat, input logic [1:0] pat0, input bit keep_start,
                              output int nvalid, output int ndone, output logic [7:0] fc_end);
        int w, h, lw, p, eof_off, end_f, t, r, ln, x, efc, pend_t;
        logic [1:0] applied, lpat;
        logic [23:0] px;
        logic [31:0] acc, pend_v;
        logic [53:0] exp_v;
        logic [32:0] exp_cs;
        bit act, esv, going;
        w = PW[k]; h = PH[k]; lw = w + PHB[k]; p = h * lw + PVB[k];
        eof_off = (h - 1) * lw + w - 1;
        end_f = (nf == 0) ? BIG : nf;
        nvalid = 0; ndone = 0; pend_t = -1; acc = 0; pend_v = 0; lpat = pat0;
        num[k] = 8'(nf); psel[k] = pat0; applied = pat0; start[k] = 1'b1;
        @(posedge pixclk); #1;
        if (!keep_start) start[k] = 1'b0;
        t = 0; going = 1;
        while (going) begin
            r = t % p; ln = r / lw; x = r % lw;
            act = (t < end_f * p) && (ln < h) && (x < w);
            if (act && x == 0 && ln == 0) lpat = applied;
            efc = (t <= eof_off) ? 0 : ((t - 1 - eof_off) / p + 1);
            if (efc > end_f) efc = end_f;
            px = act ? model_pix(x, ln, lpat, 8'(efc), w) : 24'h0;
            exp_v = {act, act && x == 0 && ln == 0, act && x == w - 1, act && x == w - 1 && ln == h - 1,
                     t < end_f * p, t == end_f * p, act ? 12'(x) : 12'd0, act ? 12'(ln) : 12'd0, px};
            n_checks++;
            if (obs(k) !== exp_v)
                $display("FAIL stream k=%0d t=%0d got %h expected %h", k, t, obs(k), exp_v);
            else n_pass++;
            n_checks++;
            if (fcnt[k] !== 8'(efc))
                $display("FAIL frame_cnt k=%0d t=%0d got %0d expected %0d", k, t, fcnt[k], efc);
            else n_pass++;
            esv = 0;
            if (t == pend_t) begin
                fs_model[k] = pend_v;
                esv = 1;
            end
            if (act) begin
                acc = ((x == 0 && ln == 0) ? 32'd0 : acc) + 32'(px[23:16]) + 32'(px[15:8]) + 32'(px[7:0]);
                if (x == w - 1 && ln == h - 1) begin
                    pend_t = t + 1;
                    pend_v = acc;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            exp_cs = {esv, fs_model[k]};
`else
            exp_cs = 33'd0;
`endif
            n_checks++;
            if ({sv[k], fsum[k]} !== exp_cs)
                $display("FAIL checksum k=%0d t=%0d got %h expected %h", k, t, {sv[k], fsum[k]}, exp_cs);
            else n_pass++;
            nvalid += int'(valid[k]);
            ndone += int'(done[k]);
            fc_end = fcnt[k];
            if (t >= end_f * p + 1 || t >= max_t) going = 0;
            else begin
                if (rand_pat) psel[k] = 2'($urandom_range(0, 3));
                applied = psel[k];
                stop[k] = (t == stop_t);
                if (t == stop_t && t / p + 1 < end_f) end_f = t / p + 1;
                @(posedge pixclk); #1;
                t++;
            end
        end
        stop[k] = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 2'b00; start = 2'b00; stop = 2'b00;
        repeat (2) @(posedge pixclk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs(k) !== 54'd0) $display("FAIL reset_out k=%0d got %h required 0", k, obs(k));
            else n_pass++;
            n_checks++;
            if ({fcnt[k], sv[k], fsum[k]} !== 41'd0)
                $display("FAIL reset_cnt k=%0d got %h required 0", k, {fcnt[k], sv[k], fsum[k]});
            else n_pass++;
            fs_model[k] = 32'd0;
        end
        rstn = 2'b11;
    endtask

    task automatic test_single_frame;
        int nv, nd;
        logic [7:0] fc;
        run_stream(0, 1, -1, BIG, 0, 2'd0, 0, nv, nd, fc);
        n_checks++;
        if (nv !== 32) $display("FAIL single_pixels got %0d required 32", nv); else n_pass++;
        n_checks++;
        if (nd !== 1 || fc !== 8'd1) $display("FAIL single_done got %0d/%0d required 1/1", nd, fc); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int nv, nd;
        logic [7:0] fc;
        run_stream(1, 3, -1, BIG, 1, 2'd0, 0, nv, nd, fc);
        n_checks++;
        if (nv !== 120 || nd !== 1 || fc !== 8'd3)
            $display("FAIL b2b got %0d/%0d/%0d required 120/1/3", nv, nd, fc);
        else n_pass++;
    endtask

    task automatic test_bars;
        int nv, nd;
        logic [7:0] fc;
        run_stream(1, 1, -1, BIG, 0, 2'd1, 0, nv, nd, fc);
        n_checks++;
        if (nv !== 40 || nd !== 1) $display("FAIL bars got %0d/%0d required 40/1", nv, nd); else n_pass++;
    endtask

    task automatic test_stop;
        int nv, nd;
        logic [7:0] fc;
        run_stream(0, 0, 2 * 43 + 10, BIG, 0, 2'd3, 0, nv, nd, fc);
        n_checks++;
        if (nv !== 96 || nd !== 1 || fc !== 8'd3)
            $display("FAIL stop_cont got %0d/%0d/%0d required 96/1/3", nv, nd, fc);
        else n_pass++;
        run_stream(0, 2, 43 + 5, BIG, 0, 2'd3, 0, nv, nd, fc);
        n_checks++;
        if (nv !== 64 || nd !== 1 || fc !== 8'd2)
            $display("FAIL stop_finite got %0d/%0d/%0d required 64/1/2", nv, nd, fc);
        else n_pass++;
    endtask

    task automatic test_stop_idle;
        int nv, nd;
        logic [7:0] fc;
        stop[0] = 1'b1;
        repeat (3) begin
            @(posedge pixclk); #1;
        end
        n_checks++;
        if (busy[0] !== 1'b0) $display("FAIL stop_idle_busy got %b required 0", busy[0]); else n_pass++;
        stop[0] = 1'b0;
        run_stream(0, 2, -1, BIG, 1, 2'd2, 0, nv, nd, fc);
        n_checks++;
        if (nd !== 1 || fc !== 8'd2) $display("FAIL stop_idle got %0d/%0d required 1/2", nd, fc); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int nv, nd;
        logic [7:0] fc;
        run_stream(0, 0, -1, 43 + 25, 0, 2'd3, 0, nv, nd, fc);
        rstn[0] = 1'b0;
        @(posedge pixclk); #1;
        n_checks++;
        if (obs(0) !== 54'd0 || fcnt[0] !== 8'd0)
            $display("FAIL reset_mid got %h/%0d required 0/0", obs(0), fcnt[0]);
        else n_pass++;
        n_checks++;
        if ({sv[0], fsum[0]} !== 33'd0) $display("FAIL reset_mid_sum got %h required 0", {sv[0], fsum[0]});
        else n_pass++;
        rstn[0] = 1'b1;
        fs_model[0] = 32'd0;
        run_stream(0, 1, -1, BIG, 0, 2'd3, 0, nv, nd, fc);
        n_checks++;
        if (fc !== 8'd1) $display("FAIL reset_restart got %0d required 1", fc); else n_pass++;
    endtask

    task automatic test_retrigger;
        int nv, nd, nv2, nd2;
        logic [7:0] fc;
        run_stream(0, 1, -1, BIG, 1, 2'd0, 1, nv, nd, fc);
        run_stream(0, 1, -1, BIG, 1, 2'd0, 0, nv2, nd2, fc);
        n_checks++;
        if (nd + nd2 !== 2 || nv + nv2 !== 64)
            $display("FAIL retrigger got %0d/%0d required 2/64", nd + nd2, nv + nv2);
        else n_pass++;
    endtask

    task automatic test_checksum;
        int nv, nd;
        logic [7:0] fc;
        logic [32:0] req;
        run_stream(0, 1, -1, BIG, 0, 2'd2, 0, nv, nd, fc);
`ifdef FRAME_CHECKSUM_EN
        req = {1'b0, 32'd24480};
`else
        req = 33'd0;
`endif
        n_checks++;
        if ({sv[0], fsum[0]} !== req) $display("FAIL checksum_white got %h required %h", {sv[0], fsum[0]}, req);
        else n_pass++;
    endtask

    task automatic test_random;
        int nv, nd, k, nf, p, st;
        logic [7:0] fc;
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, 1);
            nf = $urandom_range(1, 3);
            p = PH[k] * (PW[k] + PHB[k]) + PVB[k];
            st = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nf * p - 1) : -1;
            run_stream(k, nf, st, BIG, 1, 2'($urandom_range(0, 3)), 0, nv, nd, fc);
            n_checks++;
            if (nd !== 1) $display("FAIL random_done k=%0d got %0d required 1", k, nd); else n_pass++;
        end
    endtask

    initial begin
        pixclk = 1'b0;
        rstn = 2'b00; start = 2'b00; stop = 2'b00;
        num = '0; psel = '0;
        fs_model[0] = 32'd0;
        fs_model[1] = 32'd0;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_bars;
        test_stop;
        test_stop_idle;
        test_reset_mid;
        test_retrigger;
        test_checksum;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
